// File: rtl/alu_rx_pkg.sv
// alu_rx_pkg: shared types and parity helper for the ALU serial link receiver.
package alu_rx_pkg;
    localparam int MAX_DATA_W = 64;
    typedef enum logic {WORD_DATA = 1'b0, WORD_CMD = 1'b1} word_type_t;
    typedef enum logic {COLLECT = 1'b0, PENDING_CHECK = 1'b1} rx_state_t;
    typedef struct packed {
        logic overflow;
        logic parity;
    } rx_err_t;
    // Narrower payloads are zero-extended, which leaves the XOR unchanged.
    function automatic logic parity_calc(input logic typ, input logic [MAX_DATA_W-1:0] data, input logic odd);
        return typ ^ (^data) ^ odd;
    endfunction
endpackage

// File: rtl/alu_word_rx.sv
// alu_word_rx: deserialises one parity-protected word (type, data MSB first, parity) per WORD_W sampled bits.
module alu_word_rx
    import alu_rx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_n,
    input  logic              din,
    output logic              word_done,
    output word_type_t        word_type,
    output logic [DATA_W-1:0] word_data,
    output logic              parity_ok,
    output logic              frame_err
);
    localparam int WORD_W = DATA_W + 2;
    localparam int CW = $clog2(WORD_W + 1);
    localparam logic [CW-1:0] LAST = CW'(WORD_W - 1);
    logic [DATA_W:0] sr;
    logic [CW-1:0]   cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            sr        <= '0;
            word_done <= 1'b0;
            word_type <= WORD_DATA;
            word_data <= '0;
            parity_ok <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            word_done <= 1'b0;
            frame_err <= 1'b0;
            if (!enable_n) begin
                sr <= {sr[DATA_W-1:0], din};
                if (cnt == LAST) begin
                    cnt       <= '0;
                    word_done <= 1'b1;
                    word_type <= word_type_t'(sr[DATA_W]);
                    word_data <= sr[DATA_W-1:0];
                    parity_ok <= din == parity_calc(sr[DATA_W], MAX_DATA_W'(sr[DATA_W-1:0]), PARITY_ODD != 0);
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (cnt != '0) begin
                cnt       <= '0;
                frame_err <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/alu_serial_rx.sv
// alu_serial_rx: assembles received words into operand/command packets on a valid/ready interface.
module alu_serial_rx
    import alu_rx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int MAX_OPS    = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable_n,
    input  logic                        din,
    output logic                        pkt_valid,
    input  logic                        pkt_ready,
    output logic [DATA_W-1:0]           pkt_cmd,
    output logic [MAX_OPS*DATA_W-1:0]   pkt_ops,
    output logic [$clog2(MAX_OPS+1)-1:0] pkt_count,
    output logic [1:0]                  pkt_err,
    output logic                        frame_err,
    output logic                        overrun
);
    localparam int CW = $clog2(MAX_OPS + 1);
    localparam logic [CW-1:0] LAST_OP = CW'(MAX_OPS - 1);
    logic                      word_done, parity_ok, cmd_done;
    word_type_t                word_type;
    logic [DATA_W-1:0]         word_data;
    rx_state_t                 state, state_d;
    logic [CW-1:0]             op_cnt;
    logic [MAX_OPS*DATA_W-1:0] ops_q;
    rx_err_t                   err_q, pkt_err_q;

    alu_word_rx #(.DATA_W(DATA_W), .PARITY_ODD(PARITY_ODD)) u_word_rx (
        .clk(clk), .rst(rst), .enable_n(enable_n), .din(din),
        .word_done(word_done), .word_type(word_type), .word_data(word_data),
        .parity_ok(parity_ok), .frame_err(frame_err)
    );

    assign cmd_done = word_done && word_type == WORD_CMD;
    assign pkt_err  = pkt_err_q;

    // PENDING_CHECK: buffer full, further data words only flag overflow.
    always_ff @(posedge clk) begin
        if (rst) state <= COLLECT;
        else     state <= state_d;
    end

    always_comb begin
        state_d = (frame_err || cmd_done) ? COLLECT :
                  (word_done && state == COLLECT && op_cnt == LAST_OP) ? PENDING_CHECK : state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_cnt    <= '0;
            ops_q     <= '0;
            err_q     <= '0;
            pkt_valid <= 1'b0;
            pkt_cmd   <= '0;
            pkt_ops   <= '0;
            pkt_count <= '0;
            pkt_err_q <= '0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (pkt_valid && pkt_ready) pkt_valid <= 1'b0;
            if (frame_err) begin
                op_cnt <= '0;
                ops_q  <= '0;
                err_q  <= '0;
            end else if (cmd_done) begin
                if (!pkt_valid || pkt_ready) begin
                    pkt_valid <= 1'b1;
                    pkt_cmd   <= word_data;
                    pkt_ops   <= ops_q;
                    pkt_count <= op_cnt;
                    pkt_err_q <= {err_q.overflow, err_q.parity | !parity_ok};
                end else begin
                    overrun <= 1'b1;
                end
                op_cnt <= '0;
                ops_q  <= '0;
                err_q  <= '0;
            end else if (word_done) begin
                if (state == COLLECT) begin
                    for (int i = 0; i < MAX_OPS; i++)
                        if (op_cnt == CW'(i)) ops_q[i*DATA_W +: DATA_W] <= word_data;
                    op_cnt <= op_cnt + 1'b1;
                end else begin
                    err_q.overflow <= 1'b1;
                end
                if (!parity_ok) err_q.parity <= 1'b1;
            end
        end
    end
endmodule

// File: doc/alu_serial_rx.md
Name: alu_serial_rx

Overview:
Synthesizable receiver for the ALU serial link protocol, generalised in data width and operand count. It deserialises parity-protected words from din while enable_n is low. Data words accumulate into an operand buffer; a command word closes the packet and presents it on a valid/ready parallel interface with error flags. It sits between the serial pins and the ALU core, and replaces fixed two-operand byte framing.

Parameters:
DATA_W, 8, payload bits per word; serial word length WORD_W = DATA_W+2.
MAX_OPS, 4, operand buffer depth (data words per packet), >=1.
PARITY_ODD, 0, 0 = even parity (parity bit = XOR of type bit and data), 1 = inverted.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
enable_n  in  1  low = serial word transfer in progress
din  in  1  serial data, MSB first
pkt_valid  out  1  packet available
pkt_ready  in  1  consumer accepts packet
pkt_cmd  out  DATA_W  command payload
pkt_ops  out  MAX_OPS*DATA_W  operand i in slice [i*DATA_W +: DATA_W]; unused slices are 0
pkt_count  out  $clog2(MAX_OPS+1)  number of valid operands
pkt_err  out  2  {overflow, parity}, sticky over the packet
frame_err  out  1  one-cycle pulse: enable_n rose mid-word
overrun  out  1  one-cycle pulse: packet completed while the previous one was unaccepted; new packet dropped

Behaviour:
- Word format, first to last bit: type (0 = data, 1 = command), data[DATA_W-1:0] MSB first, parity. din is sampled only on edges where enable_n==0.
- Word receiver: the bit counter advances on each sampled bit. On sample WORD_W it emits word_done for one cycle carrying type, data and parity_ok, and the counter returns to 0.
- enable_n high with counter != 0: discard the partial word, clear the operand buffer and packet errors, pulse frame_err next cycle. enable_n high with counter == 0: idle, no effect.
- Assembly FSM states are COLLECT and PENDING_CHECK; the output slot is independent.
  - data word with op_cnt < MAX_OPS: store at index op_cnt and increment op_cnt.
  - data word with op_cnt == MAX_OPS: discard the word and set overflow.
  - any word with parity_ok == 0: set parity; the word is still stored or used.
  - command word: latch the packet into the output slot. If the slot is free (or being accepted this cycle), pkt_valid=1 on the next edge. Otherwise drop the packet and pulse overrun. In both cases clear op_cnt, buffer and errors.
- Latency: pkt_valid rises exactly 1 clk after the edge sampling the command word's parity bit.
- Handshake: pkt_* outputs are stable while pkt_valid && !pkt_ready. Transfer happens on an edge with pkt_valid && pkt_ready, and pkt_valid falls next edge unless a new packet loads on that same edge; in that case pkt_valid stays high with the new contents.
- A command word with zero operands is legal: pkt_count = 0, all pkt_ops zero.
- Reset: pkt_valid = 0, pkt_cmd = 0, pkt_ops = 0, pkt_count = 0, pkt_err = 0, frame_err = 0, overrun = 0, bit counter = 0, op_cnt = 0, buffer cleared. Reset wins over every simultaneous event, including mid-word, so the partial word is lost with no frame_err.
- Back-to-back words with no enable_n gap are accepted, and the counter wraps cleanly.

Decomposition:
- Package alu_rx_pkg: word_type_t enum {WORD_DATA = 0, WORD_CMD = 1}, rx_state_t enum, rx_err_t packed struct {overflow, parity}, and function parity_calc(type, data) honouring PARITY_ODD. The bench reuses parity_calc.
- Sub-module alu_word_rx (params DATA_W, PARITY_ODD): bit counter, shift register, parity check, word_done / word_type / word_data / parity_ok / frame_err outputs.

Test Plan:
- Data 0x12 (word 0_00010010_0), data 0x34 (0_00110100_1), command 0x01 (1_00000001_0), pkt_ready = 1 -> 1 clk after the last bit: pkt_valid = 1 for 1 cycle, pkt_count = 2, pkt_ops[7:0] = 0x12, pkt_ops[15:8] = 0x34, pkt_ops[31:16] = 0, pkt_cmd = 0x01, pkt_err = 00.
- Same packet but data 0x34 sent with parity bit 0 -> pkt_err = 01, operands still 0x12 and 0x34.
- Five data words 0x01..0x05 then command 0x02 (MAX_OPS = 4) -> pkt_count = 4, ops 0x01..0x04, pkt_err = 10.
- enable_n raised after 5 bits of a word, then a full packet [0xAA, cmd 0x03] -> frame_err pulses once; packet shows count = 1, op 0xAA, cmd 0x03, err = 00.
- pkt_ready = 0 with two packets [0x11, cmd 0x01] then [0x22, cmd 0x02] -> first packet held stable and overrun pulses at the second command. Raising pkt_ready accepts 0x11 / 0x01, then pkt_valid falls.
- rst asserted mid-way through a command word, then packet [0x7F, cmd 0x04] -> no pkt_valid and no frame_err from the aborted packet; the next packet is delivered correctly.
